fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 15 +
 rtl/fetch_sequencer_key_debounce.sv | 55 +++++
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, PC step and default halt word.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } fetch_state_e;

  // Instructions are 32-bit words in a byte-addressed ROM.
  localparam logic [7:0]  PC_INC            = 8'd4;
  localparam logic [31:0] DEFAULT_HALT_CODE = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_key_debounce.sv
// Single-step key conditioning: 2-flop synchronizer, stability counter and
// a one-cycle step pulse on the debounced press edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic step_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;

  // Count consecutive synced samples that disagree with the debounced level;
  // any agreeing sample restarts the count, so bounces never get through.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    step_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        step_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounced level, counter and registered step pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-step or free-run fetch from a
// synchronous ROM, with halt detection and a byte-lane LED display.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          RUN_DIV         = 4,
  parameter logic [31:0] HALT_CODE       = DEFAULT_HALT_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button_i,
  input  logic        run_i,
  input  logic [1:0]  select_i,
  input  logic [31:0] memDout_i,
  output logic        memEn_o,
  output logic [7:0]  memAddr_o,
  output logic [7:0]  pc_o,
  output logic [31:0] instCode_o,
  output logic        instValid_o,
  output logic        halted_o,
  output logic [7:0]  led_o
);

  localparam int               DIV_W    = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  fetch_state_e     state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [31:0]      instCode_q, instCode_d;
  logic             halted_q, halted_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [7:0]       led_q, ledSel;
  logic             stepPulse;
  logic             runTick;
  logic             memEn;
  logic             instValid;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_keyDebounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .button_i(button_i),
    .step_o  (stepPulse)
  );

  // Run-mode divider: held at zero unless free-running and not halted.
  always_comb begin
    runTick  = run_i && !halted_q && (divCnt_q == DIV_LAST);
    divCnt_d = divCnt_q + 1'b1;
    if (!run_i || halted_q || runTick) begin
      divCnt_d = '0;
    end
  end

  // Fetch FSM next state and datapath; requests outside IDLE are simply ignored.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instCode_d = instCode_q;
    halted_d   = halted_q;
    memEn      = 1'b0;
    instValid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (stepPulse || runTick) state_d = ISSUE;
      end
      ISSUE: begin
        memEn   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        instCode_d = memDout_i;
        pc_d       = pc_q + PC_INC;
        state_d    = LATCH;
      end
      LATCH: begin
        instValid = 1'b1;
        if (run_i && (instCode_q == HALT_CODE)) halted_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!run_i) halted_d = 1'b0;
  end

  // Byte lane of the current instruction to show on the LEDs.
  always_comb begin
    ledSel = instCode_q[7:0];
    case (select_i)
      2'd0: ledSel = instCode_q[7:0];
      2'd1: ledSel = instCode_q[15:8];
      2'd2: ledSel = instCode_q[23:16];
      2'd3: ledSel = instCode_q[31:24];
      default: ledSel = instCode_q[7:0];
    endcase
  end

  // State, PC, instruction, halt flag, divider and LED registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instCode_q <= '0;
      halted_q   <= 1'b0;
      divCnt_q   <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instCode_q <= instCode_d;
      halted_q   <= halted_d;
      divCnt_q   <= divCnt_d;
      led_q      <= ledSel;
    end
  end

  assign memEn_o     = memEn;
  assign memAddr_o   = pc_q;
  assign pc_o        = pc_q;
  assign instCode_o  = instCode_q;
  assign instValid_o = instValid;
  assign halted_o    = halted_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural 1-cycle-latency ROM.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstN;
  logic        button;
  logic        run;
  logic [1:0]  select;
  logic [31:0] memDout;
  logic        memEn;
  logic [7:0]  memAddr;
  logic [7:0]  pc;
  logic [31:0] instCode;
  logic        instValid;
  logic        halted;
  logic [7:0]  led;

  logic [31:0] rom [0:63];

  int          cycleCount;
  int          memEnCount;
  int          validCount;
  int          lastValidCycle;
  logic [7:0]  memAddrLog [8];
  int          memCycleLog [8];

  int          assertCount;
  int          failCount;

  fetch_sequencer #(
    .DEBOUNCE_CYCLES(16),
    .RUN_DIV        (4),
    .HALT_CODE      (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .button_i   (button),
    .run_i      (run),
    .select_i   (select),
    .memDout_i  (memDout),
    .memEn_o    (memEn),
    .memAddr_o  (memAddr),
    .pc_o       (pc),
    .instCode_o (instCode),
    .instValid_o(instValid),
    .halted_o   (halted),
    .led_o      (led)
  );

  // 100 MHz style clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data appears the cycle after the enabled address.
  always @(posedge clk) begin
    if (memEn) memDout <= rom[memAddr[7:2]];
  end

  // Free-running cycle counter used to time fetch events.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Record every ROM read and every instruction-valid pulse.
  always @(negedge clk) begin
    if (rstN) begin
      if (memEn) begin
        memAddrLog[memEnCount % 8]  <= memAddr;
        memCycleLog[memEnCount % 8] <= cycleCount;
        memEnCount                  <= memEnCount + 1;
      end
      if (instValid) begin
        validCount     <= validCount + 1;
        lastValidCycle <= cycleCount;
      end
    end
  end

  // Hard time limit so a hung DUT can never stall the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic buttonIn, input logic runIn, input logic [1:0] selectIn);
    button = buttonIn;
    run    = runIn;
    select = selectIn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    waitCycles(3);
    @(negedge clk);
    rstN = 1'b1;
    #1;
  endtask

  task automatic pressButton(input logic runIn);
    applyStimulus(1'b1, runIn, 2'd0);
    waitCycles(30);
    applyStimulus(1'b0, runIn, 2'd0);
    waitCycles(30);
  endtask

  int          baseMem;
  int          baseValid;
  int          startCycle;
  bit          found;
  logic [7:0]  ledExp [4];

  initial begin
    assertCount = 0;
    failCount   = 0;
    cycleCount  = 0;
    memEnCount  = 0;
    validCount  = 0;
    lastValidCycle = 0;
    memDout     = '0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
    $display("[TB] fetch_sequencer directed test start");

    // Reset values and a clean single step.
    rom[0] = 32'h1234_5678;
    doReset();
    checkOutput("resetPc", {24'd0, pc}, 32'h0);
    checkOutput("resetInst", instCode, 32'h0);
    checkOutput("resetLed", {24'd0, led}, 32'h0);
    checkOutput("resetHalted", {31'd0, halted}, 32'h0);
    checkOutput("resetMemEn", {31'd0, memEn}, 32'h0);
    checkOutput("resetValid", {31'd0, instValid}, 32'h0);
    baseMem    = memEnCount;
    baseValid  = validCount;
    startCycle = cycleCount;
    pressButton(1'b0);
    checkOutput("stepFetchCount", 32'(memEnCount - baseMem), 32'd1);
    checkOutput("stepAddr", {24'd0, memAddrLog[baseMem % 8]}, 32'h00);
    checkOutput("stepIssueDelay", 32'(memCycleLog[baseMem % 8] - startCycle), 32'd19);
    checkOutput("stepValidCount", 32'(validCount - baseValid), 32'd1);
    checkOutput("stepValidLatency", 32'(lastValidCycle - (startCycle + 18)), 32'd3);
    checkOutput("stepInst", instCode, 32'h1234_5678);
    checkOutput("stepPc", {24'd0, pc}, 32'h04);

    // Bouncing key then a long hold gives exactly one fetch.
    doReset();
    baseMem = memEnCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 2'd0);
      waitCycles(1);
    end
    applyStimulus(1'b1, 1'b0, 2'd0);
    waitCycles(100);
    applyStimulus(1'b0, 1'b0, 2'd0);
    waitCycles(30);
    checkOutput("bounceFetchCount", 32'(memEnCount - baseMem), 32'd1);
    checkOutput("bounceAddr", {24'd0, memAddrLog[baseMem % 8]}, 32'h00);
    checkOutput("bouncePc", {24'd0, pc}, 32'h04);

    // Free-run up to PC 0xFC, then a single step wraps the PC.
    rom[0] = 32'hC0DE_0000;
    doReset();
    applyStimulus(1'b0, 1'b1, 2'd0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      waitCycles(1);
      if (pc == 8'hFC) found = 1'b1;
    end
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkOutput("wrapReach", {24'd0, pc}, 32'hFC);
    waitCycles(5);
    baseMem = memEnCount;
    pressButton(1'b0);
    checkOutput("wrapFetchCount", 32'(memEnCount - baseMem), 32'd1);
    checkOutput("wrapAddr", {24'd0, memAddrLog[baseMem % 8]}, 32'hFC);
    checkOutput("wrapInst", instCode, 32'hC0DE_003F);
    checkOutput("wrapPc", {24'd0, pc}, 32'h00);

    // Run mode stops on the halt word; steps still fetch while halted.
    rom[0] = 32'h1;
    rom[1] = 32'h2;
    rom[2] = 32'h0;
    rom[3] = 32'h55;
    doReset();
    baseMem = memEnCount;
    applyStimulus(1'b0, 1'b1, 2'd0);
    waitCycles(40);
    checkOutput("runFetchCount", 32'(memEnCount - baseMem), 32'd3);
    checkOutput("runAddr0", {24'd0, memAddrLog[baseMem % 8]}, 32'h00);
    checkOutput("runAddr1", {24'd0, memAddrLog[(baseMem + 1) % 8]}, 32'h04);
    checkOutput("runAddr2", {24'd0, memAddrLog[(baseMem + 2) % 8]}, 32'h08);
    checkOutput("runSpacing01", 32'(memCycleLog[(baseMem + 1) % 8] - memCycleLog[baseMem % 8]), 32'd4);
    checkOutput("runSpacing12", 32'(memCycleLog[(baseMem + 2) % 8] - memCycleLog[(baseMem + 1) % 8]), 32'd4);
    checkOutput("runHalted", {31'd0, halted}, 32'h1);
    checkOutput("runHaltPc", {24'd0, pc}, 32'h0C);
    pressButton(1'b1);
    checkOutput("haltedStepCount", 32'(memEnCount - baseMem), 32'd4);
    checkOutput("haltedStepInst", instCode, 32'h55);
    checkOutput("haltedStays", {31'd0, halted}, 32'h1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    waitCycles(1);
    checkOutput("haltClear", {31'd0, halted}, 32'h0);

    // Reset during WAIT aborts the fetch and restarts from address 0.
    rom[0] = 32'hC0DE_0000;
    rom[1] = 32'hC0DE_0001;
    rom[2] = 32'hC0DE_0002;
    doReset();
    pressButton(1'b0);
    pressButton(1'b0);
    checkOutput("abortSetupPc", {24'd0, pc}, 32'h08);
    baseMem = memEnCount;
    applyStimulus(1'b1, 1'b0, 2'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      waitCycles(1);
      if (memEnCount > baseMem) found = 1'b1;
    end
    checkOutput("abortIssueSeen", {31'd0, found}, 32'h1);
    @(posedge clk);
    #2;
    baseValid = validCount;
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    #1;
    checkOutput("abortPc", {24'd0, pc}, 32'h00);
    waitCycles(3);
    @(negedge clk);
    rstN = 1'b1;
    waitCycles(5);
    checkOutput("abortNoValid", 32'(validCount - baseValid), 32'd0);
    baseMem = memEnCount;
    pressButton(1'b0);
    checkOutput("abortRefetchAddr", {24'd0, memAddrLog[baseMem % 8]}, 32'h00);
    checkOutput("abortRefetchPc", {24'd0, pc}, 32'h04);

    // LED shows the selected byte one cycle after the select change.
    rom[0] = 32'hA1B2_C3D4;
    ledExp[0] = 8'hD4;
    ledExp[1] = 8'hC3;
    ledExp[2] = 8'hB2;
    ledExp[3] = 8'hA1;
    doReset();
    pressButton(1'b0);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 1'b0, 2'(s));
      if (s == 1) checkOutput("ledLatencyHold", {24'd0, led}, 32'hD4);
      waitCycles(1);
      checkOutput($sformatf("ledSel%0d", s), {24'd0, led}, {24'd0, ledExp[s]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
